// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: sequencing FSM for the 4-way set-associative L1 cache.
// Resolves CPU line requests as hits, or runs writeback-then-refill on a
// miss, and drives the datapath load strobes plus the ctrl_state select.
// The state is registered; outputs are decoded from state and the
// current-cycle hit/dirty/mem_resp inputs, so a hit answers in COMPARE.
// Optional feature macro: CACHE_PERF_EN adds hit/miss/writeback counters
// (CNT_W wide, wrapping). Without it the counter ports are tied to 0.
module cache_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_read,
    input  logic             cpu_write,
    output logic             cpu_resp,
    output logic             mem_read,
    output logic             mem_write,
    input  logic             mem_resp,
    input  logic             ctrl_hit,
    input  logic             ctrl_dirty_out,
    output logic             ctrl_tag_ld,
    output logic             ctrl_valid_ld,
    output logic             ctrl_dirty_ld,
    output logic             ctrl_dirty_in,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_FILL  = 2'b00;
    localparam logic [1:0] SEL_WRITE = 2'b01;
    localparam logic [1:0] SEL_NONE  = 2'b10;

    state_t state;
    logic   req;

    // Write wins when both request lines are high; either one is a request.
    assign req = cpu_read | cpu_write;

    // State register and transitions; reset aborts any pmem handshake in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) state <= COMPARE;
                end
                COMPARE: begin
                    if (!req)                state <= IDLE;
                    else if (ctrl_hit)       state <= IDLE;
                    else if (ctrl_dirty_out) state <= WRITEBACK;
                    else                     state <= ALLOCATE;
                end
                WRITEBACK: begin
                    if (mem_resp) state <= ALLOCATE;
                end
                ALLOCATE: begin
                    // Return to COMPARE so the refilled line resolves as a hit
                    // and a pending write merges through the normal hit path.
                    if (mem_resp) state <= COMPARE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode: strobes low and no array write unless a state asks.
    always_comb begin
        cpu_resp      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ctrl_tag_ld   = 1'b0;
        ctrl_valid_ld = 1'b0;
        ctrl_dirty_ld = 1'b0;
        ctrl_dirty_in = 1'b0;
        ctrl_state    = SEL_NONE;
        unique case (state)
            IDLE: ;
            COMPARE: begin
                if (req && ctrl_hit) begin
                    cpu_resp = 1'b1;
                    if (cpu_write) begin
                        ctrl_state    = SEL_WRITE;
                        ctrl_dirty_ld = 1'b1;
                        ctrl_dirty_in = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                mem_write = 1'b1;
                // Clearing dirty on the victim flips the datapath mem_addr to
                // the CPU address for the refill that follows.
                if (mem_resp) begin
                    ctrl_state    = SEL_FILL;
                    ctrl_dirty_ld = 1'b1;
                end
            end
            ALLOCATE: begin
                mem_read   = 1'b1;
                ctrl_state = SEL_FILL;
                if (mem_resp) begin
                    ctrl_tag_ld   = 1'b1;
                    ctrl_valid_ld = 1'b1;
                    ctrl_dirty_ld = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef CACHE_PERF_EN
    logic [CNT_W-1:0] hit_q;
    logic [CNT_W-1:0] miss_q;
    logic [CNT_W-1:0] wb_q;

    // Event counters; a dropped request in COMPARE is neither hit nor miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
            wb_q   <= '0;
        end else begin
            if (state == COMPARE && req && ctrl_hit)  hit_q  <= hit_q + 1'b1;
            if (state == COMPARE && req && !ctrl_hit) miss_q <= miss_q + 1'b1;
            if (state == WRITEBACK && mem_resp)       wb_q   <= wb_q + 1'b1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule
